seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_pkg.sv | 8 +
 rtl/sat_counter.sv | 40 ++++
 rtl/seq_detect_param.sv | 101 ++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared defaults for the parameterised serial sequence detector.
package seq_detect_pkg;

  localparam int         PAT_W_DEF   = 4;
  localparam logic [3:0] PATTERN_DEF = 4'b1010;
  localparam int         CNT_W_DEF   = 8;

endpackage : seq_detect_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear first, then a saturating increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous reset to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule : sat_counter

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with a Mealy match flag.
// Optional feature macro: SEQ_DETECT_CNT_EN -- when defined, a saturating
// match counter (cleared by cnt_clr) drives match_cnt; otherwise match_cnt
// reads zero and cnt_clr has no effect.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF,
  parameter int               CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             mode_ovl,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  // Fill only needs to reach PAT_W-1, the number of history bits.
  localparam int               FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [FILL_W-1:0] FILL_ONE = {{(FILL_W-1){1'b0}}, 1'b1};

  logic [PAT_W-2:0]  hist_d, hist_q;
  logic [FILL_W-1:0] fill_d, fill_q;
  logic [PAT_W-1:0]  pat_d,  pat_q;
  logic              match_s;

  // Mealy detect: the incoming bit completes the window without a register.
  always_comb begin
    match_s = in_valid && (fill_q == FILL_MAX) && ({hist_q, in_bit} == pat_q);
  end

  // History / fill / pattern next state; a pattern load restarts filling
  // while the current-cycle compare still uses the old pattern.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    if (in_valid) begin
      hist_d = (PAT_W-1)'({hist_q, in_bit});
      if (match_s) begin
        if (mode_ovl) begin
          fill_d = fill_q;
        end else begin
          fill_d = {FILL_W{1'b0}};
        end
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_ONE;
      end else begin
        fill_d = fill_q;
      end
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = {FILL_W{1'b0}};
    end else begin
      pat_d  = pat_q;
    end
  end

  // Detector state registers; reset restores the build-time pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= {(PAT_W-1){1'b0}};
      fill_q <= {FILL_W{1'b0}};
      pat_q  <= PATTERN;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
    end
  end

  assign match = match_s;

`ifdef SEQ_DETECT_CNT_EN
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (match_s),
    .q     (match_cnt)
  );
`else
  logic unused_cnt_clr_s;
  assign unused_cnt_clr_s = cnt_clr;
  assign match_cnt        = {CNT_W{1'b0}};
`endif

endmodule : seq_detect_param
